// File: rtl/occupancy_counter_multi.sv
// Multi-doorway occupancy counter.
// Each door has an outer and an inner presence sensor. Every sensor goes
// through a 2-FF synchroniser and a debouncer. A direction FSM per door then
// turns the order in which the sensors change into enter and exit commits.
// A shared register adds up all commits from one cycle and clamps the result
// to [0, MAX_OCC].
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset; asserts at once, releases synchronously
//   sens_out     outer sensors, one per door, active-high, asynchronous to clk
//   sens_in      inner sensors, one per door, active-high, asynchronous to clk
//   clr          synchronous clear of occupancy and sat_err
//   occupancy    current person count
//   empty        high when occupancy == 0
//   full         high when occupancy == MAX_OCC
//   enter_pulse  one-cycle pulse per committed entry, one bit per door
//   exit_pulse   one-cycle pulse per committed exit, one bit per door
//   sat_err      sticky flag, set when a commit was clipped by saturation
//
// Per-door FSM states:
//   state      | meaning
//   IDLE       | both sensors clear, waiting for a pass
//   OUT_FIRST  | outer sensor tripped first, possible entry
//   IN_FIRST   | inner sensor tripped first, possible exit
//   ENTER_WAIT | both sensors seen in entry order; commits +1 when both clear
//   EXIT_WAIT  | both sensors seen in exit order; commits -1 when both clear
//   WAIT_CLEAR | ambiguous or timed-out pass; waits for both clear, no count
module occupancy_counter_multi #(
  parameter int N_DOORS      = 2,
  parameter int CNT_W        = 5,
  parameter int MAX_OCC      = 31,
  parameter int DEBOUNCE_CYC = 50_000,
  parameter int TIMEOUT_CYC  = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DOORS-1:0] sens_out,
  input  logic [N_DOORS-1:0] sens_in,
  input  logic               clr,
  output logic [CNT_W-1:0]   occupancy,
  output logic               empty,
  output logic               full,
  output logic [N_DOORS-1:0] enter_pulse,
  output logic [N_DOORS-1:0] exit_pulse,
  output logic               sat_err
);

  localparam int NS    = 2 * N_DOORS;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SUM_W = CNT_W + 4;

  localparam logic [DB_W-1:0]         DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TO_W-1:0]         TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic signed [SUM_W-1:0] MAX_S   = SUM_W'(MAX_OCC);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_OUT_FIRST  = 3'd1;
  localparam logic [2:0] S_IN_FIRST   = 3'd2;
  localparam logic [2:0] S_ENTER_WAIT = 3'd3;
  localparam logic [2:0] S_EXIT_WAIT  = 3'd4;
  localparam logic [2:0] S_WAIT_CLEAR = 3'd5;

  // Reset synchroniser: assertion is asynchronous, release is aligned to clk.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Input conditioning. The low half of the vector holds the outer sensors
  // and the high half holds the inner sensors.
  logic [NS-1:0]            raw, sync1, sync2, deb;
  logic [NS-1:0][DB_W-1:0]  db_cnt;
  logic [N_DOORS-1:0]       o_db, i_db;

  assign raw = {sens_in, sens_out};

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int k = 0; k < NS; k++) begin
        if (sync2[k] == deb[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          deb[k]    <= ~deb[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign o_db = deb[N_DOORS-1:0];
  assign i_db = deb[NS-1:N_DOORS];

  // Per-door direction FSMs
  logic [N_DOORS-1:0][2:0]      state_q, state_d;
  logic [N_DOORS-1:0][TO_W-1:0] timer_q;
  logic [N_DOORS-1:0]           timing, tmo, inc, dec;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= '0;
    else            state_q <= state_d;
  end

  // The timer restarts on every state change, so each phase of a pass gets
  // its own TIMEOUT_CYC window.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      timer_q <= '0;
    end else begin
      for (int d = 0; d < N_DOORS; d++) begin
        if (state_d[d] != state_q[d]) timer_q[d] <= '0;
        else if (timing[d])           timer_q[d] <= timer_q[d] + 1'b1;
      end
    end
  end

  // A timeout takes priority over any other transition on the same edge.
  always_comb begin
    state_d = state_q;
    timing  = '0;
    tmo     = '0;
    for (int d = 0; d < N_DOORS; d++) begin
      timing[d] = (state_q[d] != S_IDLE) && (state_q[d] != S_WAIT_CLEAR);
      tmo[d]    = timing[d] && (timer_q[d] == TO_LAST);
      if (tmo[d]) begin
        state_d[d] = S_WAIT_CLEAR;
      end else begin
        case (state_q[d])
          S_IDLE: begin
            if (o_db[d] && i_db[d])       state_d[d] = S_WAIT_CLEAR;
            else if (o_db[d])             state_d[d] = S_OUT_FIRST;
            else if (i_db[d])             state_d[d] = S_IN_FIRST;
          end
          S_OUT_FIRST: begin
            if (i_db[d])                  state_d[d] = S_ENTER_WAIT;
            else if (!o_db[d])            state_d[d] = S_IDLE;
          end
          S_IN_FIRST: begin
            if (o_db[d])                  state_d[d] = S_EXIT_WAIT;
            else if (!i_db[d])            state_d[d] = S_IDLE;
          end
          S_ENTER_WAIT, S_EXIT_WAIT, S_WAIT_CLEAR: begin
            if (!o_db[d] && !i_db[d])     state_d[d] = S_IDLE;
          end
          default:                        state_d[d] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int d = 0; d < N_DOORS; d++) begin
      if (!tmo[d] && !o_db[d] && !i_db[d]) begin
        inc[d] = (state_q[d] == S_ENTER_WAIT);
        dec[d] = (state_q[d] == S_EXIT_WAIT);
      end
    end
  end

  // Shared count with clamping
  logic signed [SUM_W-1:0] net, sum;
  logic [CNT_W-1:0]        occ_d;
  logic                    clip;

  always_comb begin
    net = '0;
    for (int d = 0; d < N_DOORS; d++) begin
      net = net + $signed(SUM_W'(inc[d])) - $signed(SUM_W'(dec[d]));
    end
    sum   = $signed(SUM_W'(occupancy)) + net;
    occ_d = sum[CNT_W-1:0];
    clip  = 1'b0;
    if (sum[SUM_W-1]) begin
      occ_d = '0;
      clip  = 1'b1;
    end else if (sum > MAX_S) begin
      occ_d = CNT_W'(MAX_OCC);
      clip  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      occupancy   <= '0;
      sat_err     <= 1'b0;
      enter_pulse <= '0;
      exit_pulse  <= '0;
    end else begin
      enter_pulse <= inc;
      exit_pulse  <= dec;
      if (clr) begin
        occupancy <= '0;
        sat_err   <= 1'b0;
      end else begin
        occupancy <= occ_d;
        if (clip) sat_err <= 1'b1;
      end
    end
  end

  assign empty = (occupancy == '0);
  assign full  = (occupancy == CNT_W'(MAX_OCC));

endmodule

// File: tb/tb_occupancy_counter_multi.sv
module tb_occupancy_counter_multi;

  localparam int N   = 2;
  localparam int CW  = 5;
  localparam int MAX = 3;
  localparam int DEB = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  sens_out = '0;
  logic [N-1:0]  sens_in = '0;
  logic [CW-1:0] occupancy;
  logic          empty, full, sat_err;
  logic [N-1:0]  enter_pulse, exit_pulse;

  occupancy_counter_multi #(
    .N_DOORS(N), .CNT_W(CW), .MAX_OCC(MAX), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sens_out(sens_out), .sens_in(sens_in), .clr(clr),
    .occupancy(occupancy), .empty(empty), .full(full),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .sat_err(sat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] ex;
    int           occ;
    bit           sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_occ = 0;
  bit   model_sat = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int d, input bit o, input bit i);
    sens_out[d] = o;
    sens_in[d]  = i;
  endtask

  task automatic phase(input int d, input bit o, input bit i);
    drive(d, o, i);
    wait_cyc($urandom_range(8, 20));
  endtask

  // Reference: a full pass changes the count by +1/-1 per door, and the sum
  // of one cycle's commits is clamped to [0, MAX].
  task automatic expect_commit(input logic [N-1:0] en, input logic [N-1:0] ex);
    int nx;
    nx = model_occ + $countones(en) - $countones(ex);
    if (nx < 0) begin
      nx = 0;
      model_sat = 1;
    end else if (nx > MAX) begin
      nx = MAX;
      model_sat = 1;
    end
    model_occ = nx;
    sb_q.push_back('{en, ex, model_occ, model_sat});
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_occ"},   int'(occupancy), model_occ);
    chk({tag, "_empty"}, int'(empty),     int'(model_occ == 0));
    chk({tag, "_full"},  int'(full),      int'(model_occ == MAX));
    chk({tag, "_sat"},   int'(sat_err),   int'(model_sat));
  endtask

  task automatic release_door(input int d);
    drive(d, 0, 0);
    wait_cyc(16);
  endtask

  // kind: 0 entry, 1 exit, 2 outer abort, 3 inner abort, 4 ambiguous,
  //       5 inner held with short outer glitch, 6 clear
  task automatic run_seq(input int d, input int kind);
    logic [N-1:0] m;
    m = '0;
    m[d] = 1'b1;
    case (kind)
      0: begin
        phase(d, 1, 0); phase(d, 1, 1); phase(d, 0, 1);
        expect_commit(m, '0);
        release_door(d);
      end
      1: begin
        phase(d, 0, 1); phase(d, 1, 1); phase(d, 1, 0);
        expect_commit('0, m);
        release_door(d);
      end
      2: begin phase(d, 1, 0); release_door(d); end
      3: begin phase(d, 0, 1); release_door(d); end
      4: begin phase(d, 1, 1); release_door(d); end
      5: begin
        drive(d, 0, 1);
        wait_cyc(10);
        sens_out[d] = 1'b1;
        wait_cyc($urandom_range(1, DEB - 1));
        sens_out[d] = 1'b0;
        wait_cyc(10);
        release_door(d);
      end
      default: begin
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        model_occ = 0;
        model_sat = 0;
        wait_cyc(1);
      end
    endcase
    check_quiet($sformatf("seq_d%0d_k%0d", d, kind));
  endtask

  // Monitor: every cycle with a pulse must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ((enter_pulse | exit_pulse) != '0)) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", int'({enter_pulse, exit_pulse}), 0);
        end else begin
          e = sb_q.pop_front();
          chk("enter_pulse", int'(enter_pulse), int'(e.en));
          chk("exit_pulse",  int'(exit_pulse),  int'(e.ex));
          chk("commit_occ",  int'(occupancy),   e.occ);
          chk("commit_sat",  int'(sat_err),     int'(e.sat));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wait_cyc(3);
    check_quiet("reset");
    chk("reset_pulses", int'({enter_pulse, exit_pulse}), 0);
    rst_n = 1'b1;
    wait_cyc(4);

    run_seq(0, 0);                   // entry -> 1
    run_seq(1, 1);                   // exit -> 0
    run_seq(0, 2);                   // abort, no change

    // Timeout in OUT_FIRST, then an inner pulse while stuck in WAIT_CLEAR
    drive(0, 1, 0);
    wait_cyc(80);
    sens_in[0] = 1'b1;
    wait_cyc(10);
    sens_in[0] = 1'b0;
    wait_cyc(10);
    release_door(0);
    check_quiet("timeout");
    run_seq(0, 0);                   // FSM back in IDLE: entry counts -> 1
    run_seq(1, 1);                   // -> 0

    // Saturation at the top, then exit and clear
    for (int k = 0; k < 4; k++) run_seq(k % 2, 0);
    run_seq(1, 1);                   // -> 2, sat stays
    run_seq(0, 6);                   // clr
    run_seq(0, 0);
    run_seq(1, 0);                   // -> 2

    // Simultaneous entry on door0 and exit on door1
    drive(0, 1, 0); drive(1, 0, 1); wait_cyc(12);
    drive(0, 1, 1); drive(1, 1, 1); wait_cyc(12);
    drive(0, 0, 1); drive(1, 1, 0); wait_cyc(12);
    expect_commit(2'b01, 2'b10);
    drive(0, 0, 0); drive(1, 0, 0); wait_cyc(16);
    check_quiet("simul");

    // Two-cycle outer glitch during an inner-first pass must not count
    drive(0, 0, 1);
    wait_cyc(10);
    sens_out[0] = 1'b1;
    wait_cyc(2);
    sens_out[0] = 1'b0;
    wait_cyc(10);
    release_door(0);
    check_quiet("glitch");

    // Reset while door0 sits in ENTER_WAIT
    phase(0, 1, 0);
    phase(0, 1, 1);
    drive(0, 0, 1);
    wait_cyc(10);
    rst_n = 1'b0;
    #1;
    model_occ = 0;
    model_sat = 0;
    chk("rst_mid_occ",   int'(occupancy), 0);
    chk("rst_mid_empty", int'(empty),     1);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(12);
    release_door(0);
    check_quiet("rst_mid_after");

    // Randomised passes, one door at a time
    for (int k = 0; k < 40; k++) begin
      run_seq($urandom_range(0, N - 1), $urandom_range(0, 6));
    end

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/occupancy_counter_multi.md
# occupancy_counter_multi

Parametrised multi-doorway occupancy counter for the room controller. It replaces the single-door people counter that drives the "room empty" condition to the alarm and the displayed person count. Each doorway has an outer and an inner presence sensor. A per-door direction FSM turns the sensor order into enter and exit events. A shared, saturating occupancy register combines the events from all doors in the same cycle and reports empty, full and error status.

## Interface
- `N_DOORS`, 2, number of doorways (1..8)
- `CNT_W`, 5, occupancy width
- `MAX_OCC`, 31, occupancy ceiling; must be < 2^CNT_W
- `DEBOUNCE_CYC`, 50_000, cycles an input must be stable before it is accepted (1 ms @ 50 MHz)
- `TIMEOUT_CYC`, 100_000_000, maximum cycles allowed for one pass (2 s)
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  asynchronous active-low reset
- `sens_out`  in  N_DOORS  outer sensors, active-high, asynchronous to `clk`
- `sens_in`  in  N_DOORS  inner sensors, active-high, asynchronous to `clk`
- `clr`  in  1  synchronous clear of the count and the sticky error
- `occupancy`  out  CNT_W  current number of persons
- `empty`  out  1  high when `occupancy == 0`
- `full`  out  1  high when `occupancy == MAX_OCC`
- `enter_pulse`  out  N_DOORS  one-cycle pulse per committed entry
- `exit_pulse`  out  N_DOORS  one-cycle pulse per committed exit
- `sat_err`  out  1  sticky flag: a commit was clipped by saturation

## Operation
- **Input conditioning:** every sensor passes through a 2-FF synchroniser, then a debouncer.
  - Debouncer counter is cleared whenever the synced value equals the debounced value.
  - Otherwise it increments; on reaching `DEBOUNCE_CYC-1` the debounced value toggles.
- **Per-door FSM states:** IDLE, OUT_FIRST, IN_FIRST, ENTER_WAIT, EXIT_WAIT, WAIT_CLEAR. O and I below are the debounced outer and inner sensors.
  - IDLE: O&!I -> OUT_FIRST; I&!O -> IN_FIRST; O&I -> WAIT_CLEAR (ambiguous, no count).
  - OUT_FIRST: I -> ENTER_WAIT; !O&!I -> IDLE (abort).
  - IN_FIRST: O -> EXIT_WAIT; !O&!I -> IDLE (abort).
  - ENTER_WAIT: !O&!I -> IDLE and commit +1. EXIT_WAIT: !O&!I -> IDLE and commit -1.
  - WAIT_CLEAR: !O&!I -> IDLE.
  - Timeout: a per-door timer runs in every state except IDLE and WAIT_CLEAR and reloads on entry. When it reaches `TIMEOUT_CYC-1` the FSM goes to WAIT_CLEAR with no commit.
- **Count arithmetic:**
  - Each cycle, net = (number of +1 commits) - (number of -1 commits), computed signed in CNT_W+4 bits.
  - next = occupancy + net, clamped to [0, MAX_OCC].
  - If clamping changed the value, `sat_err` is set.
- **Event pulses:** `enter_pulse[d]` and `exit_pulse[d]` fire on every commit, including clipped ones.
- **Clear:** `clr` has priority over same-cycle commits. It sets occupancy to 0 and clears `sat_err`. It does not affect the FSMs or the pulses.
- **Flags:** `empty` and `full` are decoded combinationally from the `occupancy` register.

## Timing
- **Reset** (async assert, sync release), all cleared:
  - FSMs go to IDLE; timers, debouncers and synchronisers are zero.
  - occupancy=0, empty=1, full=0, sat_err=0, all pulses 0.
  - Reset during a pass discards that pass.
- **Input latency:** a clean sensor edge reaches the FSM 2+DEBOUNCE_CYC cycles after it arrives at the pin. Glitches shorter than DEBOUNCE_CYC are ignored.
- **Commit timing:** on the edge where a WAIT state sees both sensors released, the FSM returns to IDLE and `occupancy` updates. The pulse is registered high for exactly the following cycle.
- **Simultaneous events:** all doors commit in the same cycle and no commit is lost. For example, with occupancy 0, +1 and -1 in the same cycle give net 0, occupancy stays 0, and `sat_err` is not set.
- **Wrap-around:** never; the register saturates at both ends.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, TIMEOUT_CYC=64, MAX_OCC=3, N_DOORS=2.
- **Entry:** door0 sequence O, O+I, I, none, each held 10 cycles -> occupancy 0->1, `enter_pulse[0]` high for one cycle, empty 1->0.
- **Exit and abort:** door1 sequence I, I+O, O, none -> occupancy 1->0. Then door0 sequence O, none -> no change, no pulse.
- **Timeout:** door0 holds O for 100 cycles -> OUT_FIRST times out to WAIT_CLEAR, no count. Releasing O returns the FSM to IDLE. Before release, an I pulse does not count.
- **Saturation:** four entries -> occupancy 3, full=1, 4th `enter_pulse` present, sat_err=1. An exit -> 2, full=0, sat_err stays 1. `clr` -> 0, sat_err=0.
- **Simultaneous:** occupancy 2; door0 entry and door1 exit released on the same cycle -> both pulses in the same cycle, occupancy stays 2. A 2-cycle glitch on O is ignored.
- **Reset mid-op:** rst_n low while door0 is in ENTER_WAIT with occupancy 2 -> occupancy 0 immediately. After release, the remaining sensor release produces no count.
